wb_cmd_master: RTL and testbench

//  Wishbone classic initiator: turns one-at-a-time commands (address, data, sel, we) into single

---
 rtl/wb_master_pkg.sv | 16 +
 rtl/wb_cmd_master.sv | 96 +++++++++
 tb/tb_wb_cmd_master.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared state encoding and sizing helpers for the Wishbone command master
package wb_master_pkg;

    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone classic initiator driven by a command/response handshake
import wb_master_pkg::*;

module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    localparam int CW = cnt_width(TIMEOUT);

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic          accept, hit_ack, hit_to, consume;

    // next-state decode and transaction events
    always_comb begin
        accept    = (state == IDLE) && cmd_valid && cmd_ready;
        hit_ack   = (state == BUS) && wbm_ack_i;
        hit_to    = (state == BUS) && !wbm_ack_i && (count == CW'(TIMEOUT - 1));
        consume   = (state == RESP) && rsp_ready;
        state_nxt = state;
        if (accept)
            state_nxt = BUS;
        else if (hit_ack || hit_to)
            state_nxt = RESP;
        else if (consume)
            state_nxt = IDLE;
    end

    // state register plus all registered bus and response outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            if (accept) begin
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
                wbm_sel_o <= cmd_sel;
                wbm_we_o  <= cmd_we;
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                count     <= '0;
            end
            if (state == BUS && !wbm_ack_i)
                count <= (count == CW'(TIMEOUT)) ? count : count + 1'b1;
            if (hit_ack || hit_to) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= hit_to;
                rsp_dat   <= (hit_ack && !wbm_we_o) ? wbm_dat_i : '0;
            end
            if (consume) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_dat   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed-vector check of the Wishbone command master with a short timeout
module tb_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [3:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic          wbm_ack_i = 1'b0;
    logic [DW-1:0] wbm_dat_i = '0;

    int n_cmp = 0;
    int n_bad = 0;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic offer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("drain_valid", rsp_valid, 0);
        check("drain_ready", cmd_ready, 1);
    endtask

    initial begin
        // reset
        tick();
        tick();
        wb_rst_i = 1'b0;
        check("rst_ready", cmd_ready, 1);
        check("rst_valid", rsp_valid, 0);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);

        // stray ack while idle is ignored
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        check("idle_ack_valid", rsp_valid, 0);
        check("idle_ack_ready", cmd_ready, 1);

        // write, ack in third bus cycle
        offer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        check("wr_ready", cmd_ready, 0);
        for (int i = 0; i < 3; i++) begin
            check("wr_cyc", wbm_cyc_o, 1);
            check("wr_stb", wbm_stb_o, 1);
            check("wr_adr", wbm_adr_o, 32'h3000_0004);
            check("wr_dat", wbm_dat_o, 32'hDEAD_BEEF);
            check("wr_sel", wbm_sel_o, 4'hF);
            check("wr_we", wbm_we_o, 1);
            check("wr_pending", rsp_valid, 0);
            if (i == 2) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'hFFFF_FFFF;
            end
            tick();
        end
        wbm_ack_i = 1'b0;
        check("wr_cyc_drop", wbm_cyc_o, 0);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_dat", rsp_dat, 0);
        drain();

        // read, ack in first bus cycle
        offer(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        check("rd_cyc", wbm_cyc_o, 1);
        check("rd_we", wbm_we_o, 0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_cyc_drop", wbm_cyc_o, 0);
        drain();

        // read with no ack: timeout after 4 bus cycles
        wbm_dat_i = 32'h5555_AAAA;
        offer(1'b0, 32'h3000_0008, 32'h0, 4'h3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_cyc_held", wbm_cyc_o, 1);
            check("to_no_rsp", rsp_valid, 0);
        end
        tick();
        check("to_cyc", wbm_cyc_o, 0);
        check("to_stb", wbm_stb_o, 0);
        check("to_valid", rsp_valid, 1);
        check("to_err", rsp_err, 1);
        check("to_dat", rsp_dat, 0);
        drain();

        // ack on the timeout edge wins, then response held under backpressure
        offer(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) tick();
        check("edge_cyc", wbm_cyc_o, 1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hA5A5_0F0F;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        check("edge_err", rsp_err, 0);
        check("edge_dat", rsp_dat, 32'hA5A5_0F0F);
        check("edge_valid", rsp_valid, 1);
        cmd_valid = 1'b1;
        cmd_adr   = 32'h3000_0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_dat", rsp_dat, 32'hA5A5_0F0F);
            check("hold_ready", cmd_ready, 0);
            check("hold_cyc", wbm_cyc_o, 0);
        end
        cmd_valid = 1'b0;
        drain();

        // reset in the middle of a bus cycle
        offer(1'b1, 32'h3000_0014, 32'h0BAD_CAFE, 4'h1);
        tick();
        check("mid_cyc", wbm_cyc_o, 1);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        check("mid_rst_cyc", wbm_cyc_o, 0);
        check("mid_rst_stb", wbm_stb_o, 0);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", cmd_ready, 1);
        offer(1'b0, 32'h3000_0018, 32'h0, 4'hF);
        check("post_adr", wbm_adr_o, 32'h3000_0018);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0BAD_F00D;
        tick();
        wbm_ack_i = 1'b0;
        check("post_valid", rsp_valid, 1);
        check("post_dat", rsp_dat, 32'h0BAD_F00D);
        check("post_err", rsp_err, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
